// File: rtl/rom_byte_fifo.sv
// ============================================================================
// rom_byte_fifo : first-word-fall-through capture FIFO for ROM {addr, byte}
//                 pairs, with end-of-sweep tagging and sticky overflow.
//                 Optional running checksum: define ROM_FIFO_CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rom_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 8,
  parameter int AW    = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DW-1:0]              in_data,
  input  logic [AW-1:0]              in_addr,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [DW-1:0]              out_data,
  output logic [AW-1:0]              out_addr,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [DW-1:0]              checksum
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DW + AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, drop;
  logic [EW-1:0] head_entry;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign out_valid = !empty;
  assign count     = count_q;
  assign overflow  = overflow_q;

  // A full FIFO refuses the incoming pair even if the head pops this cycle.
  assign push = in_valid && !full;
  assign drop = in_valid && full;
  assign pop  = out_valid && out_ready;

  assign head_entry = mem_q[rd_ptr_q];
  assign out_data   = empty ? '0   : head_entry[DW-1:0];
  assign out_addr   = empty ? '0   : head_entry[DW +: AW];
  assign out_last   = empty ? 1'b0 : head_entry[EW-1];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is left unreset; the empty gating hides stale contents.
  always_ff @(posedge clk) begin
    if (!rst && push)
      mem_q[wr_ptr_q] <= {(in_addr == {AW{1'b1}}), in_addr, in_data};
  end

`ifdef ROM_FIFO_CHECKSUM_EN
  logic [DW-1:0] checksum_q, checksum_d;

  // Address 0 marks a new sweep, so the sum restarts there.
  always_comb begin
    checksum_d = checksum_q;
    if (push) begin
      if (in_addr == '0) checksum_d = in_data;
      else               checksum_d = checksum_q + in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) checksum_q <= '0;
    else     checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

`default_nettype wire

// File: doc/rom_byte_fifo.md
# rom_byte_fifo

Downstream capture buffer for the ROM sweep stage. Accepts one {address, byte} pair per cycle from the ROM's `data_out`/`addr_out`, stores it in a first-word-fall-through FIFO, and presents it to a consumer via a valid/ready handshake. It flags sweep boundaries and reports sticky overflow when the consumer stalls. An optional running checksum is also available.

## Interface
- `DEPTH`, 16: number of FIFO entries; power of two, ≥ 2.
- `DW`, 8: data width; matches ROM `data_out`.
- `AW`, 10: address width; matches ROM `addr_out`.

- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: ROM pair present this cycle.
- `in_data` in DW: ROM byte.
- `in_addr` in AW: ROM address of that byte.
- `out_ready` in 1: consumer accepts head entry.
- `out_valid` out 1: head entry available.
- `out_data` out DW: head byte.
- `out_addr` out AW: head address.
- `out_last` out 1: head entry was captured at address all-ones (end of sweep).
- `count` out log2(DEPTH)+1: entries held.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `overflow` out 1: sticky; a pair was dropped.
- `checksum` out DW: running sum (see Configuration).

## Operation
- Storage: DEPTH entries of {last, addr, data}. Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is a separate register.
- Push: `in_valid && !full`. The entry written is `{in_addr == {AW{1'b1}}, in_addr, in_data}`. `wr_ptr` increments.
- Drop: `in_valid && full`. The entry is discarded and `overflow` is set to 1. It stays 1 until `rst`.
- Pop: `out_valid && out_ready`. `rd_ptr` increments.
- `full` blocks push even when a pop occurs in the same cycle; no pass-through when full.
- Simultaneous push and pop: both pointers advance and `count` is unchanged.
- Push while empty: `out_valid` cannot pop in the same cycle.
- `out_ready` while empty: ignored, no state change.
- Head outputs are a combinational read of `mem[rd_ptr]`, gated to 0 when empty. `out_data`, `out_addr` and `out_last` are all 0 whenever `empty` is 1.
- `out_valid = !empty`. `full` and `empty` are decoded from the registered `count`.
- Control states (derived from `count`):
  - EMPTY: 0 entries.
  - PARTIAL: 1..DEPTH-1 entries.
  - FULL: DEPTH entries.
  - Transitions: ±1 on a lone push or lone pop; no change otherwise.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_addr`=0, `out_last`=0, `count`=0, `full`=0, `empty`=1, `overflow`=0, `checksum`=0. Both pointers are 0.
- Memory contents are not reset; they are unobservable because of the empty gating.
- Latency: a push at edge N makes `out_valid`=1 with that entry on the head after edge N. The entry is poppable at edge N+1.
- Throughput: one push and one pop per cycle sustained in PARTIAL.
- `rst` mid-operation: all buffered entries are discarded, the sticky flag and checksum are cleared, and `in_valid` in the reset cycle is ignored.
- Pointer wrap: after DEPTH pushes, `wr_ptr` returns to 0. FIFO order is preserved across the wrap.

## Configuration
- `ROM_FIFO_CHECKSUM_EN` defined:
  - On each push, `checksum <= checksum + in_data` (mod 2^DW).
  - If `in_addr == 0`, `checksum <= in_data` instead, restarting the sum at each sweep start.
  - Drops do not update `checksum`.
- `ROM_FIFO_CHECKSUM_EN` undefined: the accumulator is not built and `checksum` is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then hold idle 4 cycles -> `empty`=1, `count`=0, `out_valid`=0, `out_data`=0, `overflow`=0.
- Push addr 0..3 with data 0x10..0x13, `out_ready`=0 -> `count`=4. Head shows addr 0, data 0x10. With `out_ready`=1, pops return 0x10, 0x11, 0x12, 0x13 in order, then `empty`=1.
- Push 17 pairs with `out_ready`=0 (DEPTH=16) -> `full`=1 after the 16th and `overflow`=1 after the 17th. Draining yields exactly 16 entries; the 17th is absent. `overflow` stays 1 until `rst`.
- Continuous push and pop for 40 cycles, addr 1020..1023 then 0..35 -> `count` stays constant. Wrap order is preserved. `out_last`=1 only on the addr 1023 entry.
- With `ROM_FIFO_CHECKSUM_EN`: push addr 0..3 with data 0xFF, 0x02, 0x03, 0x04 -> `checksum`=0x08. A subsequent push at addr 0 with data 0x05 -> `checksum`=0x05. Without the macro, `checksum`=0 throughout.
- Assert `rst` for one cycle with 5 entries buffered and `in_valid`=1 -> next cycle `count`=0, `empty`=1, `checksum`=0. The `in_valid` pair from the reset cycle is not stored.
